// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
// Shared types and helpers for the button conditioning path.
//   btn_state_e : debounce FSM states
//   cnt_width() : bits needed to hold the value n (i.e. $clog2(n+1))
// ---------------------------------------------------------------------------
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_ff2.sv
// ---------------------------------------------------------------------------
// sync_ff2
// Generic two-flop synchronizer for a single asynchronous input bit.
// Usable for any GPI pin entering the system clock domain.
// Parameters:
//   RST_VAL : value both flops take during reset
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   i_d   in  asynchronous input
//   o_q   out synchronized output (two clk edges of latency)
// ---------------------------------------------------------------------------
module sync_ff2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // First flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/btn_conditioner.sv
// ---------------------------------------------------------------------------
// btn_conditioner
// Turns the raw, bouncing user button into a clean pressed level plus
// single-cycle press/release events (and optionally a long-press event)
// for the core's GPI inputs.
//
// Optional feature: define BTN_LONG_PRESS_EN to enable long-press detection.
// Without it long_o is tied 0 and LONG_CYCLES has no effect.
//
// Parameters:
//   ACTIVE_LOW      : 1 = pin reads low while pressed, 0 = high while pressed
//   DEBOUNCE_CYCLES : cycles a new level must be stable before acceptance (>= 2)
//   LONG_CYCLES     : held cycles after press_o before long_o (> DEBOUNCE_CYCLES)
// Ports:
//   clk       in  system clock
//   rst_n     in  asynchronous active-low reset
//   btn_i     in  raw button pin, asynchronous to clk
//   level_o   out debounced level, 1 = pressed
//   press_o   out one-cycle pulse on accepted press
//   release_o out one-cycle pulse on accepted release
//   long_o    out one-cycle pulse on long-press detection
// ---------------------------------------------------------------------------
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 480000,
  parameter int LONG_CYCLES     = 48000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  // Pin level that corresponds to "not pressed"; synchronizer resets here.
  localparam logic RAW_RELEASED = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

`ifdef BTN_LONG_PRESS_EN
  localparam int CNT_W = cnt_width(LONG_CYCLES);
`else
  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES - 1);
`endif

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic       w_syncBtn;
  logic       w_act;

  btn_state_e r_state;
  btn_state_e w_stateNext;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;
  logic       r_level;
  logic       w_levelNext;
  logic       r_press;
  logic       w_pressNext;
  logic       r_release;
  logic       w_releaseNext;

  sync_ff2 #(
    .RST_VAL(RAW_RELEASED)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (btn_i),
    .o_q  (w_syncBtn)
  );

  // Normalize to active-high so the FSM only ever reasons about "pressed".
  assign w_act = (ACTIVE_LOW != 0) ? ~w_syncBtn : w_syncBtn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RELEASED;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_cnt     <= w_cntNext;
      r_level   <= w_levelNext;
      r_press   <= w_pressNext;
      r_release <= w_releaseNext;
    end
  end

  // The counter is compared before it is incremented, so it tops out at
  // DEB_LAST and can never wrap. Any disagreement in a WAIT state restarts
  // the debounce from the stable side.
  always_comb begin
    w_stateNext   = r_state;
    w_cntNext     = r_cnt;
    w_levelNext   = r_level;
    w_pressNext   = 1'b0;
    w_releaseNext = 1'b0;
    case (r_state)
      RELEASED: begin
        if (w_act) begin
          w_stateNext = PRESS_WAIT;
          w_cntNext   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_act) begin
          w_stateNext = RELEASED;
          w_cntNext   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_stateNext = PRESSED;
          w_pressNext = 1'b1;
          w_levelNext = 1'b1;
          w_cntNext   = '0;
        end else begin
          w_cntNext = r_cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!w_act) begin
          w_stateNext = RELEASE_WAIT;
          w_cntNext   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (w_act) begin
          w_stateNext = PRESSED;
          w_cntNext   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_stateNext   = RELEASED;
          w_releaseNext = 1'b1;
          w_levelNext   = 1'b0;
          w_cntNext     = '0;
        end else begin
          w_cntNext = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_stateNext = RELEASED;
        w_cntNext   = '0;
        w_levelNext = 1'b0;
      end
    endcase
  end

  assign level_o   = r_level;
  assign press_o   = r_press;
  assign release_o = r_release;

`ifdef BTN_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_DONE = CNT_W'(LONG_CYCLES);

  logic [CNT_W-1:0] r_lcnt;
  logic [CNT_W-1:0] w_lcntNext;
  logic       r_long;
  logic       w_longNext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lcnt <= '0;
      r_long <= 1'b0;
    end else begin
      r_lcnt <= w_lcntNext;
      r_long <= w_longNext;
    end
  end

  // lcnt keeps running through RELEASE_WAIT so a rejected release glitch does
  // not restart the hold time. It parks at LONG_DONE after firing, giving one
  // long_o per press. If the release is accepted on the very cycle the hold
  // time expires, the release wins so the pulses stay mutually exclusive.
  always_comb begin
    w_lcntNext = r_lcnt;
    w_longNext = 1'b0;
    case (r_state)
      RELEASED: begin
        w_lcntNext = '0;
      end
      PRESS_WAIT: begin
        if (w_stateNext == PRESSED) begin
          w_lcntNext = '0;
        end
      end
      PRESSED, RELEASE_WAIT: begin
        if (r_lcnt != LONG_DONE) begin
          w_lcntNext = r_lcnt + CNT_ONE;
          if ((r_lcnt == LONG_LAST) && (w_stateNext != RELEASED)) begin
            w_longNext = 1'b1;
          end
        end
      end
      default: begin
        w_lcntNext = '0;
      end
    endcase
  end

  assign long_o = r_long;
`else
  // LONG_CYCLES has no role in this build; keep it referenced.
  logic w_unusedLong;
  assign w_unusedLong = (LONG_CYCLES > DEBOUNCE_CYCLES);

  assign long_o = 1'b0;
`endif

endmodule
